vga_axil_regs: RTL and testbench
================================

VGA_AXIL_REGS -- requirements
Module: vga_axil_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5647_4131, constant value returned by the ID register.
REQ-002 SHALL have ports, one per line:
- clk  input  1  sole clock, rising edge
- arst_n  input  1  asynchronous active-low reset
- araddr, awaddr  input  axil_addr_t  read / write address
- arvalid, awvalid, wvalid, rready, bready  input  1  master handshakes
- wdata  input  axil_data_t (32)  write data
- wstrb  input  4  byte strobes
- arready, awready, wready, rvalid, bvalid  output  1  slave handshakes
- rdata  output  axil_data_t (32)  read data
- rresp, bresp  output  axil_resp_t (2)  response
- frame_done_i  input  1  one-cycle pulse per VGA frame
- enable_o  output  1  CTRL[0], VGA output enable
- test_pattern_o  output  1  CTRL[1], test-pattern select
- bg_color_o  output  12  COLOR[11:0], RGB444 background

Function
REQ-003 SHALL use the register map (word index araddr/awaddr[3:2]; [1:0] ignored): 0x0 CTRL RW bits[1:0]; 0x4 COLOR RW bits[11:0]; 0x8 FRAME_CNT RO 32-bit; 0xC ID RO; address >= 0x10 unmapped.
REQ-004 SHALL read unimplemented bits of RW registers as 0.
REQ-005 SHALL implement write FSM W_IDLE, W_GOT_AW, W_GOT_W, W_RESP: in W_IDLE awready=wready=1; AW-only handshake -> W_GOT_AW (awready=0); W-only -> W_GOT_W (wready=0); both in same cycle -> W_RESP.
REQ-006 W_GOT_AW SHALL hold wready=1 until W handshake, then W_RESP; W_GOT_W symmetrically with awready.
REQ-007 SHALL latch awaddr, wdata and wstrb at their respective handshakes; register update SHALL occur on the cycle of entering W_RESP.
REQ-008 W_RESP SHALL drive bvalid=1, awready=wready=0, bresp stable; on bready -> W_IDLE, bvalid=0 next cycle.
REQ-009 bresp SHALL be SLVERR (2'b10), with no register change, if address unmapped, targets FRAME_CNT/ID, or wstrb != 4'hF; else OKAY (2'b00).
REQ-010 SHALL implement read FSM R_IDLE (arready=1), R_RESP (arready=0, rvalid=1); AR handshake -> R_RESP next cycle with rdata/rresp registered from the handshake-cycle register values; rready -> R_IDLE.
REQ-011 Unmapped read SHALL return rdata=0, rresp=SLVERR.
REQ-012 rdata, rresp, bresp SHALL be stable while valid and not accepted; no channel SHALL handshake on two consecutive cycles.
REQ-013 Read and write FSMs SHALL run independently; read of a register in the same cycle as its update SHALL return the pre-update value.
REQ-014 FRAME_CNT SHALL increment by 1 per clk with frame_done_i=1 and wrap 32'hFFFF_FFFF -> 0.
REQ-015 enable_o, test_pattern_o, bg_color_o SHALL be direct register outputs (zero latency after update).

Reset
REQ-016 arst_n low SHALL asynchronously clear all outputs, registers, FRAME_CNT, and both FSMs to W_IDLE/R_IDLE with all ready/valid=0.
REQ-017 arready, awready, wready SHALL rise on the first clk edge after arst_n release; reset mid-transaction SHALL abort it with no response issued.

Configuration
REQ-018 With VGA_AXIL_FRAME_CNT_EN defined, FRAME_CNT SHALL behave per REQ-014; without it the counter SHALL not exist, frame_done_i SHALL be ignored, and 0x8 SHALL be unmapped (SLVERR on read and write).

Structure
REQ-019 vga_axil_pkg SHALL hold axil_addr_t, axil_data_t, axil_resp_t/axil_resp_e, register offset constants and CTRL bit indices.
REQ-020 No sub-module; the block SHALL be connectable to vga_axil_if slave signals directly.

Verification
REQ-021 Bench SHALL cover:
- write 0x4 data 32'h0000_0ABC, then read 0x4 -> bresp OKAY, bg_color_o=12'hABC, rdata=32'h0000_0ABC.
- AW valid 3 cycles before W, then W before AW -> one handshake each, one bvalid, CTRL written 2'b11 both orders.
- write 0x8, write 0x10, wstrb=4'h3 to 0x0 -> bresp SLVERR, registers unchanged; read 0x14 -> rdata 0, SLVERR.
- 5 frame_done_i pulses, read 0x8 -> 32'd5 (macro on); macro off -> SLVERR; force count 32'hFFFF_FFFF + pulse -> 0.
- bready/rready held low 4 cycles -> bvalid/rvalid, bresp/rdata stable; read 0xC -> ID_VALUE.
- arst_n asserted during W_RESP -> bvalid=0 immediately, all registers 0, readies high after release.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared types and register map for the VGA AXI-Lite register block.
// The VGA_AXIL_FRAME_CNT_EN macro adds the FRAME_CNT register at 0x8.
package vga_axil_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 2;
  localparam int COLOR_W = 12;

  typedef logic [ADDR_W-1:0] axil_addr_t;
  typedef logic [DATA_W-1:0] axil_data_t;
  typedef logic [1:0]        axil_resp_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

  localparam axil_addr_t OFS_CTRL  = 8'h00;
  localparam axil_addr_t OFS_COLOR = 8'h04;
  localparam axil_addr_t OFS_FCNT  = 8'h08;
  localparam axil_addr_t OFS_ID    = 8'h0C;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_TP_BIT = 1;

  function automatic logic [1:0] word_idx(axil_addr_t a);
    return a[3:2];
  endfunction

  function automatic logic in_range(axil_addr_t a);
    return a[ADDR_W-1:4] == '0;
  endfunction

  // One-hot register select; all zero for addresses above the map.
  function automatic logic [3:0] reg_sel(axil_addr_t a);
    return in_range(a) ? (4'b0001 << word_idx(a)) : 4'b0000;
  endfunction

endpackage

// File: rtl/vga_axil_regs.sv
// AXI-Lite slave holding VGA control, background colour, frame count and ID.
// Define VGA_AXIL_FRAME_CNT_EN to implement FRAME_CNT; otherwise 0x8 is unmapped.
module vga_axil_regs
  import vga_axil_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5647_4131
) (
  input  logic        clk,
  input  logic        arst_n,
  input  axil_addr_t  araddr,
  input  axil_addr_t  awaddr,
  input  logic        arvalid,
  input  logic        awvalid,
  input  logic        wvalid,
  input  logic        rready,
  input  logic        bready,
  input  axil_data_t  wdata,
  input  logic [3:0]  wstrb,
  output logic        arready,
  output logic        awready,
  output logic        wready,
  output logic        rvalid,
  output logic        bvalid,
  output axil_data_t  rdata,
  output axil_resp_t  rresp,
  output axil_resp_t  bresp,
  input  logic        frame_done_i,
  output logic        enable_o,
  output logic        test_pattern_o,
  output logic [11:0] bg_color_o
);

  typedef enum logic [1:0] {
    W_IDLE, W_GOT_AW, W_GOT_W, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_RESP
  } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic              rdy_en_q;
  axil_addr_t        aw_addr_q;
  axil_data_t        w_data_q;
  logic [3:0]        w_strb_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [COLOR_W-1:0] color_q;
  axil_resp_t        bresp_q;
  axil_data_t        rdata_q;
  axil_resp_t        rresp_q;

  logic       aw_hs, w_hs, ar_hs;
  logic       do_wr, wr_ok;
  axil_addr_t wa;
  axil_data_t wd;
  logic [3:0] ws;
  logic [3:0] wsel, rsel;
  axil_data_t rd_data;
  axil_resp_t rd_resp;

  // Readies stay low until the first edge after reset release.
  assign awready = rdy_en_q &
                   (w_state_q == W_IDLE || w_state_q == W_GOT_W);
  assign wready  = rdy_en_q &
                   (w_state_q == W_IDLE || w_state_q == W_GOT_AW);
  assign bvalid  = (w_state_q == W_RESP);
  assign arready = rdy_en_q & (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  assign wa = aw_hs ? awaddr : aw_addr_q;
  assign wd = w_hs ? wdata : w_data_q;
  assign ws = w_hs ? wstrb : w_strb_q;

  assign wsel  = reg_sel(wa);
  assign wr_ok = (wsel[0] | wsel[1]) & (ws == 4'hF);

  always_comb begin
    w_state_d = w_state_q;
    do_wr     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_RESP;
          do_wr     = 1'b1;
        end else if (aw_hs) begin
          w_state_d = W_GOT_AW;
        end else if (w_hs) begin
          w_state_d = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        if (w_hs) begin
          w_state_d = W_RESP;
          do_wr     = 1'b1;
        end
      end
      W_GOT_W: begin
        if (aw_hs) begin
          w_state_d = W_RESP;
          do_wr     = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

`ifdef VGA_AXIL_FRAME_CNT_EN
  axil_data_t frame_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_done_i) begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end
`endif

  assign rsel = reg_sel(araddr);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    unique case (1'b1)
      rsel[0]: begin
        rd_data = axil_data_t'(ctrl_q);
        rd_resp = RESP_OKAY;
      end
      rsel[1]: begin
        rd_data = axil_data_t'(color_q);
        rd_resp = RESP_OKAY;
      end
`ifdef VGA_AXIL_FRAME_CNT_EN
      rsel[2]: begin
        rd_data = frame_cnt_q;
        rd_resp = RESP_OKAY;
      end
`endif
      rsel[3]: begin
        rd_data = ID_VALUE;
        rd_resp = RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ctrl_q    <= '0;
      color_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (do_wr) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok && wsel[0]) ctrl_q  <= wd[CTRL_W-1:0];
        if (wr_ok && wsel[1]) color_q <= wd[COLOR_W-1:0];
      end
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  assign bresp          = bresp_q;
  assign rdata          = rdata_q;
  assign rresp          = rresp_q;
  assign enable_o       = ctrl_q[CTRL_EN_BIT];
  assign test_pattern_o = ctrl_q[CTRL_TP_BIT];
  assign bg_color_o     = color_q;

  logic unused_bits;
`ifdef VGA_AXIL_FRAME_CNT_EN
  assign unused_bits = ^{araddr[1:0], wa[1:0], wd[31:12],
                         wsel[3:2]};
`else
  assign unused_bits = ^{frame_done_i, araddr[1:0], wa[1:0],
                         wd[31:12], wsel[3:2], rsel[2]};
`endif

endmodule

// File: tb/tb_vga_axil_regs.sv
// Directed self-checking bench for vga_axil_regs.
// Expectations follow VGA_AXIL_FRAME_CNT_EN when the bench is built with it.
module tb_vga_axil_regs;
  import vga_axil_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  axil_addr_t  araddr = '0, awaddr = '0;
  logic        arvalid = 0, awvalid = 0, wvalid = 0;
  logic        rready = 0, bready = 0;
  axil_data_t  wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arready, awready, wready, rvalid, bvalid;
  axil_data_t  rdata;
  axil_resp_t  rresp, bresp;
  logic        frame_done_i = 1'b0;
  logic        enable_o, test_pattern_o;
  logic [11:0] bg_color_o;

  int n_chk = 0;
  int n_pass = 0;
  int n_aw = 0, n_w = 0, n_b = 0;

  localparam logic [31:0] ID_EXP = 32'h5647_4131;

  vga_axil_regs dut (
    .clk(clk), .arst_n(arst_n),
    .araddr(araddr), .awaddr(awaddr),
    .arvalid(arvalid), .awvalid(awvalid), .wvalid(wvalid),
    .rready(rready), .bready(bready),
    .wdata(wdata), .wstrb(wstrb),
    .arready(arready), .awready(awready), .wready(wready),
    .rvalid(rvalid), .bvalid(bvalid),
    .rdata(rdata), .rresp(rresp), .bresp(bresp),
    .frame_done_i(frame_done_i),
    .enable_o(enable_o), .test_pattern_o(test_pattern_o),
    .bg_color_o(bg_color_o)
  );

  always #5 clk = ~clk;

  // Handshakes counted mid-cycle, where they match the next edge.
  always @(negedge clk) begin
    if (awvalid && awready) n_aw++;
    if (wvalid && wready) n_w++;
    if (bvalid && bready) n_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input axil_addr_t a, input axil_data_t d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly,
                          output axil_resp_t resp);
    bit aw_d, w_d, aw_f, w_f;
    int cyc;
    axil_resp_t r0;
    aw_d = 0; w_d = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_d && w_d) && cyc < 30) begin
      if (!aw_d && cyc >= aw_dly) awvalid = 1;
      if (!w_d && cyc >= w_dly) wvalid = 1;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      step();
      if (aw_f) begin aw_d = 1; awvalid = 0; end
      if (w_f) begin w_d = 1; wvalid = 0; end
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_d && w_d)) chk("aw_w_timeout", 0, 1);
    cyc = 0;
    while (!bvalid && cyc < 10) begin step(); cyc++; end
    if (!bvalid) chk("bvalid_timeout", 0, 1);
    r0 = bresp;
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, r0);
    end
    bready = 1;
    resp = bresp;
    step();
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input axil_addr_t a, input int r_dly,
                         output axil_data_t d, output axil_resp_t resp);
    int cyc;
    bit f;
    axil_data_t d0;
    araddr = a; arvalid = 1; cyc = 0; f = 0;
    while (!f && cyc < 10) begin
      f = arready;
      step();
      cyc++;
    end
    arvalid = 0;
    if (!f) chk("ar_timeout", 0, 1);
    chk("rvalid_rise", rvalid, 1);
    d0 = rdata;
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, d0);
    end
    rready = 1;
    d = rdata;
    resp = rresp;
    step();
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  task automatic pulse_frame();
    frame_done_i = 1;
    step();
    frame_done_i = 0;
    step();
  endtask

  axil_resp_t r;
  axil_data_t d;
  int a0, w0, b0;

  initial begin
    #2;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_outs", {enable_o, test_pattern_o, bg_color_o}, 0);
    #20 arst_n = 1;
    step();
    chk("rel_readies", {arready, awready, wready}, 3'b111);

    do_write(8'h04, 32'h0000_0ABC, 4'hF, 0, 0, 0, r);
    chk("color_bresp", r, RESP_OKAY);
    chk("color_out", bg_color_o, 12'hABC);
    chk("ctrl_untouched", {enable_o, test_pattern_o}, 0);
    do_read(8'h04, 0, d, r);
    chk("color_rdata", d, 32'h0000_0ABC);
    chk("color_rresp", r, RESP_OKAY);

    a0 = n_aw; w0 = n_w; b0 = n_b;
    do_write(8'h00, 32'h0000_0003, 4'hF, 0, 3, 0, r);
    chk("awfirst_bresp", r, RESP_OKAY);
    chk("awfirst_naw", n_aw - a0, 1);
    chk("awfirst_nw", n_w - w0, 1);
    chk("awfirst_nb", n_b - b0, 1);
    chk("awfirst_ctrl", {test_pattern_o, enable_o}, 2'b11);

    do_write(8'h00, 32'h0, 4'hF, 0, 0, 0, r);
    chk("ctrl_clear", {test_pattern_o, enable_o}, 2'b00);

    a0 = n_aw; w0 = n_w; b0 = n_b;
    do_write(8'h00, 32'h0000_0003, 4'hF, 3, 0, 4, r);
    chk("wfirst_bresp", r, RESP_OKAY);
    chk("wfirst_naw", n_aw - a0, 1);
    chk("wfirst_nw", n_w - w0, 1);
    chk("wfirst_nb", n_b - b0, 1);
    chk("wfirst_ctrl", {test_pattern_o, enable_o}, 2'b11);

    do_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    chk("wr_fcnt_slverr", r, RESP_SLVERR);
    do_write(8'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    chk("wr_0x10_slverr", r, RESP_SLVERR);
    do_write(8'h0C, 32'h0, 4'hF, 0, 0, 0, r);
    chk("wr_id_slverr", r, RESP_SLVERR);
    do_write(8'h00, 32'h0, 4'h3, 0, 0, 0, r);
    chk("wr_strb_slverr", r, RESP_SLVERR);
    chk("strb_ctrl_kept", {test_pattern_o, enable_o}, 2'b11);
    chk("strb_color_kept", bg_color_o, 12'hABC);
    do_read(8'h00, 0, d, r);
    chk("ctrl_rdata", d, 32'h3);
    do_read(8'h14, 0, d, r);
    chk("rd_0x14_data", d, 32'h0);
    chk("rd_0x14_resp", r, RESP_SLVERR);

    for (int i = 0; i < 5; i++) pulse_frame();
    do_read(8'h08, 0, d, r);
`ifdef VGA_AXIL_FRAME_CNT_EN
    chk("fcnt_5", d, 32'd5);
    chk("fcnt_resp", r, RESP_OKAY);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.frame_cnt_q;
    pulse_frame();
    do_read(8'h08, 0, d, r);
    chk("fcnt_wrap", d, 32'h0);
    chk("fcnt_wrap_resp", r, RESP_OKAY);
`else
    chk("fcnt_off_data", d, 32'h0);
    chk("fcnt_off_resp", r, RESP_SLVERR);
`endif

    do_read(8'h0C, 4, d, r);
    chk("id_rdata", d, ID_EXP);
    chk("id_rresp", r, RESP_OKAY);

    awaddr = 8'h04; wdata = 32'h123; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    chk("pre_rst_bvalid", bvalid, 1);
    chk("pre_rst_color", bg_color_o, 12'h123);
    #3 arst_n = 0;
    #1;
    chk("rst_bvalid_drop", bvalid, 0);
    chk("rst_regs_clear", {enable_o, test_pattern_o, bg_color_o}, 0);
    chk("rst_readies_low", {arready, awready, wready}, 0);
    #10 arst_n = 1;
    step();
    chk("rel2_readies", {arready, awready, wready}, 3'b111);
    chk("rel2_bvalid", bvalid, 0);
    do_read(8'h00, 0, d, r);
    chk("rel2_ctrl", d, 32'h0);
    do_read(8'h04, 0, d, r);
    chk("rel2_color", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
